// File: rtl/regfile_wb_queue.sv
// Writeback feeder for the register file: merges ALU and load results into an in-order
// FIFO, drains one entry per cycle onto wb_*, and exports a per-register pending mask.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_rd,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_ready,
    output logic                     wb_we,
    output logic [AW-1:0]            wb_addr,
    output logic [DW-1:0]            wb_data,
    output logic [31:0]              busy_mask,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] rd_mem_q   [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wb_we_q;
    logic [AW-1:0] wb_addr_q;
    logic [DW-1:0] wb_data_q;

    logic [CW-1:0] free;
    logic          push_mem, push_alu, pop;
    logic [PW-1:0] alu_slot;

    // Readiness depends only on occupancy and mem_valid so the ALU path stays short.
    always_comb begin
        free      = DEPTH_C - count_q;
        mem_ready = (free >= CW'(1));
        alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_valid);
        push_mem  = mem_valid && mem_ready && (mem_rd != '0);
        push_alu  = alu_valid && alu_ready && (alu_rd != '0);
        pop       = (count_q != '0);
        alu_slot  = wr_ptr_q + PW'(push_mem);
        wr_ptr_d  = wr_ptr_q + PW'(push_mem) + PW'(push_alu);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
    end

    // The load result is older than a same-cycle ALU result, so it takes the lower slot.
    always_ff @(posedge clk) begin
        if (push_mem) begin
            rd_mem_q[wr_ptr_q]   <= mem_rd;
            data_mem_q[wr_ptr_q] <= mem_data;
        end
        if (push_alu) begin
            rd_mem_q[alu_slot]   <= alu_rd;
            data_mem_q[alu_slot] <= alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wb_we_q  <= pop;
            if (pop) begin
                wb_addr_q <= rd_mem_q[rd_ptr_q];
                wb_data_q <= data_mem_q[rd_ptr_q];
            end
        end
    end

    logic [31:0] entry_hot [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offset;
            assign offset        = PW'(gi) - rd_ptr_q;
            assign entry_hot[gi] = ({1'b0, offset} < count_q) ? (32'(1) << rd_mem_q[gi]) : 32'(0);
        end
    endgenerate

    always_comb begin
        busy_mask = wb_we_q ? (32'(1) << wb_addr_q) : 32'(0);
        for (int i = 0; i < DEPTH; i++) begin
            busy_mask = busy_mask | entry_hot[i];
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign count   = count_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed-vector bench for regfile_wb_queue: one table row per clock cycle, plus an
// ordering sequence that collects every register-file write.
module tb_regfile_wb_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] busy_mask;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_mask(busy_mask), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        chk_rdy;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_busy;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] ard,
                                input logic [31:0] ad, input logic mv, input logic [4:0] mrd,
                                input logic [31:0] md, input logic chk_rdy, input logic e_ar,
                                input logic e_mr, input logic e_we, input logic [4:0] e_addr,
                                input logic [31:0] e_data, input logic [31:0] e_busy,
                                input logic [2:0] e_cnt);
        vec_t v;
        v.rst = rst; v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
        v.chk_rdy = chk_rdy; v.e_ar = e_ar; v.e_mr = e_mr; v.e_we = e_we;
        v.e_addr = e_addr; v.e_data = e_data; v.e_busy = e_busy; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h, expected %h", idx, name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic av, input logic [4:0] ard,
                         input logic [31:0] ad, input logic mv, input logic [4:0] mrd,
                         input logic [31:0] md);
        reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
    endtask

    logic [36:0] writes [$];
    logic [36:0] exp_writes [3];

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        //              rst av ard  ad            mv mrd  md          chk ar mr we addr  data          busy          cnt
        vecs[0]  = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,     0, 0, 0, 0, 0,  32'h0,        32'h0,        0);
        // single ALU write to r3
        vecs[1]  = mk(0, 1, 3,  32'hAA,       0, 0,  32'h0,     1, 1, 1, 0, 0,  32'h0,        32'h8,        1);
        vecs[2]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,     1, 1, 1, 1, 3,  32'hAA,       32'h8,        0);
        vecs[3]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,     1, 1, 1, 0, 3,  32'hAA,       32'h0,        0);
        // same-cycle mem+alu to r5: mem first
        vecs[4]  = mk(0, 1, 5,  32'h22,       1, 5,  32'h11,    1, 1, 1, 0, 3,  32'hAA,       32'h20,       2);
        vecs[5]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,     1, 1, 1, 1, 5,  32'h11,       32'h20,       1);
        vecs[6]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,     1, 1, 1, 1, 5,  32'h22,       32'h20,       0);
        vecs[7]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,     1, 1, 1, 0, 5,  32'h22,       32'h0,        0);
        // write to r0 is swallowed
        vecs[8]  = mk(0, 1, 0,  32'hFFFFFFFF, 0, 0,  32'h0,     1, 1, 1, 0, 5,  32'h22,       32'h0,        0);
        // dual pushes while draining; alu_ready drops at free==1 with mem_valid
        vecs[9]  = mk(0, 1, 2,  32'h102,      1, 1,  32'h101,   1, 1, 1, 0, 5,  32'h22,       32'h6,        2);
        vecs[10] = mk(0, 1, 4,  32'h104,      1, 3,  32'h103,   1, 1, 1, 1, 1,  32'h101,      32'h1E,       3);
        vecs[11] = mk(0, 1, 7,  32'h107,      1, 6,  32'h106,   1, 0, 1, 1, 2,  32'h102,      32'h5C,       3);
        vecs[12] = mk(0, 1, 7,  32'h107,      0, 0,  32'h0,     1, 1, 1, 1, 3,  32'h103,      32'hD8,       3);
        vecs[13] = mk(0, 1, 9,  32'h109,      1, 8,  32'h108,   1, 0, 1, 1, 4,  32'h104,      32'h1D0,      3);
        vecs[14] = mk(0, 1, 9,  32'h109,      0, 0,  32'h0,     1, 1, 1, 1, 6,  32'h106,      32'h3C0,      3);
        vecs[15] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,     1, 1, 1, 1, 7,  32'h107,      32'h380,      2);
        vecs[16] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,     1, 1, 1, 1, 8,  32'h108,      32'h300,      1);
        vecs[17] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,     1, 1, 1, 1, 9,  32'h109,      32'h200,      0);
        vecs[18] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,     1, 1, 1, 0, 9,  32'h109,      32'h0,        0);
        // queue three entries, then reset discards them
        vecs[19] = mk(0, 1, 11, 32'h10B,      1, 10, 32'h10A,   1, 1, 1, 0, 9,  32'h109,      32'hC00,      2);
        vecs[20] = mk(0, 1, 13, 32'h10D,      1, 12, 32'h10C,   1, 1, 1, 1, 10, 32'h10A,      32'h3C00,     3);
        vecs[21] = mk(1, 0, 0,  32'h0,        1, 14, 32'h10E,   1, 0, 1, 0, 0,  32'h0,        32'h0,        0);
        vecs[22] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,     1, 1, 1, 0, 0,  32'h0,        32'h0,        0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].ad,
                  vecs[i].mv, vecs[i].mrd, vecs[i].md);
            #1;
            if (vecs[i].chk_rdy) begin
                chk("alu_ready", i, 32'(alu_ready), 32'(vecs[i].e_ar));
                chk("mem_ready", i, 32'(mem_ready), 32'(vecs[i].e_mr));
            end
            @(posedge clk);
            #1;
            chk("wb_we",     i, 32'(wb_we),   32'(vecs[i].e_we));
            chk("wb_addr",   i, 32'(wb_addr), 32'(vecs[i].e_addr));
            chk("wb_data",   i, wb_data,      vecs[i].e_data);
            chk("busy_mask", i, busy_mask,    vecs[i].e_busy);
            chk("count",     i, 32'(count),   32'(vecs[i].e_cnt));
            $display("[TB] vec %0d: we=%0b addr=%0d data=%h busy=%h count=%0d",
                     i, wb_we, wb_addr, wb_data, busy_mask, count);
        end

        // Ordering: repeated writes to r20 must commit in accept order.
        exp_writes[0] = {5'd20, 32'hA1};
        exp_writes[1] = {5'd21, 32'hB2};
        exp_writes[2] = {5'd20, 32'hC3};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            case (c)
                0:       drive(1'b0, 1'b1, 5'd21, 32'hB2, 1'b1, 5'd20, 32'hA1);
                1:       drive(1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 5'd20, 32'hC3);
                default: drive(1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0);
            endcase
            @(posedge clk);
            #1;
            if (wb_we) begin
                writes.push_back({wb_addr, wb_data});
                $display("[TB] seq write %0d: addr=%0d data=%h", writes.size() - 1, wb_addr, wb_data);
            end
        end
        chk("seq_write_count", 100, 32'(writes.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < writes.size())
                chk("seq_write", 100 + k, 32'(writes[k][36:32]) ^ writes[k][31:0],
                    32'(exp_writes[k][36:32]) ^ exp_writes[k][31:0]);
        end
        chk("seq_end_count", 110, 32'(count), 32'd0);
        chk("seq_end_busy", 110, busy_mask, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
